// File: rtl/dcache_controller_nway.sv
// Control FSM for a WAYS-way set-associative data cache: hits complete combinationally, misses and flushes
// run line-sized L2 beat bursts; each beat advances only on l2_req_fulfilled, and pipe requests are ignored while busy.
package xentry_pkg;
    typedef enum logic {LOAD = 1'b0, STORE = 1'b1} memory_operation_e;
endpackage

module dcache_controller_nway
    import xentry_pkg::*;
#(
    parameter int WAYS           = 2,
    parameter int WORDS_PER_LINE = 4,
    parameter int SETS           = 64,
    localparam int WAY_W         = (WAYS > 1) ? $clog2(WAYS) : 1,
    localparam int BEAT_W        = $clog2(WORDS_PER_LINE),
    localparam int SET_W         = (SETS > 1) ? $clog2(SETS) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              pipe_req_valid,
    input  logic              clflush_requested,
    input  logic              flush_all_requested,
    input  logic              hit,
    input  logic [WAY_W-1:0]  hit_way,
    input  logic              victim_valid,
    input  logic              victim_dirty,
    input  logic              l2_req_fulfilled,
    output logic              pipe_req_fulfilled,
    output logic              l2_req_valid,
    output memory_operation_e l2_req_type,
    output logic [WAY_W-1:0]  victim_way,
    output logic [BEAT_W-1:0] beat,
    output logic              sweep_mode,
    output logic [SET_W-1:0]  sweep_set,
    output logic              flush_mode,
    output logic              load_mode,
    output logic              set_new_l2_block_address,
    output logic              use_dirty_tag_for_l2_block_address,
    output logic              clear_selected_dirty_bit,
    output logic              clear_selected_valid_bit,
    output logic              finish_new_line_install,
    output logic              busy
);

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        WRITEBACK   = 3'd1,
        ALLOCATE    = 3'd2,
        FLUSH       = 3'd3,
        SWEEP_CHECK = 3'd4,
        SWEEP_WB    = 3'd5
    } state_e;

    state_e              r_state;
    state_e              w_state_next;
    logic [BEAT_W-1:0]   r_beat;
    logic [WAY_W-1:0]    r_rr_ptr;
    logic [WAY_W-1:0]    r_target_way;
    logic [SET_W-1:0]    r_sweep_set;
    logic [WAY_W-1:0]    r_sweep_way;
    logic                w_last_beat;
    logic                w_sweep_last_way;
    logic                w_sweep_last;
    logic                w_rr_adv;
    logic                w_sweep_adv;
    logic                w_sweep_start;

    assign w_last_beat      = l2_req_fulfilled && (r_beat == BEAT_W'(WORDS_PER_LINE - 1));
    assign w_sweep_last_way = (r_sweep_way == WAY_W'(WAYS - 1));
    assign w_sweep_last     = w_sweep_last_way && (r_sweep_set == SET_W'(SETS - 1));
    assign beat             = r_beat;
    assign sweep_set        = r_sweep_set;
    assign busy             = (r_state != IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_beat       <= '0;
            r_rr_ptr     <= '0;
            r_target_way <= '0;
            r_sweep_set  <= '0;
            r_sweep_way  <= '0;
        end else begin
            r_state <= w_state_next;
            // The counter wraps naturally on the last beat; state entry also forces it to 0.
            if (w_state_next != r_state)
                r_beat <= '0;
            else if (l2_req_valid && l2_req_fulfilled)
                r_beat <= r_beat + BEAT_W'(1);
            if ((r_state == IDLE) && (w_state_next != IDLE))
                r_target_way <= victim_way;
            if (w_rr_adv)
                r_rr_ptr <= (r_rr_ptr == WAY_W'(WAYS - 1)) ? '0 : r_rr_ptr + WAY_W'(1);
            if (w_sweep_start) begin
                r_sweep_set <= '0;
                r_sweep_way <= '0;
            end else if (w_sweep_adv) begin
                if (w_sweep_last_way) begin
                    r_sweep_way <= '0;
                    r_sweep_set <= r_sweep_set + SET_W'(1);
                end else begin
                    r_sweep_way <= r_sweep_way + WAY_W'(1);
                end
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (pipe_req_valid) begin
                    if (flush_all_requested)
                        w_state_next = SWEEP_CHECK;
                    else if (clflush_requested) begin
                        if (hit && victim_dirty)
                            w_state_next = FLUSH;
                    end else if (!hit)
                        w_state_next = (victim_valid && victim_dirty) ? WRITEBACK : ALLOCATE;
                end
            end
            WRITEBACK:   if (w_last_beat) w_state_next = ALLOCATE;
            ALLOCATE:    if (w_last_beat) w_state_next = IDLE;
            FLUSH:       if (w_last_beat) w_state_next = IDLE;
            SWEEP_CHECK: begin
                if (victim_dirty)
                    w_state_next = SWEEP_WB;
                else if (w_sweep_last)
                    w_state_next = IDLE;
            end
            SWEEP_WB:    if (w_last_beat) w_state_next = w_sweep_last ? IDLE : SWEEP_CHECK;
            default:     w_state_next = state_e'(3'bxxx);
        endcase
    end

    always_comb begin
        pipe_req_fulfilled                 = 1'b0;
        l2_req_valid                       = 1'b0;
        l2_req_type                        = LOAD;
        victim_way                         = r_target_way;
        sweep_mode                         = 1'b0;
        flush_mode                         = 1'b0;
        load_mode                          = 1'b0;
        set_new_l2_block_address           = 1'b0;
        use_dirty_tag_for_l2_block_address = 1'b0;
        clear_selected_dirty_bit           = 1'b0;
        clear_selected_valid_bit           = 1'b0;
        finish_new_line_install            = 1'b0;
        w_rr_adv                           = 1'b0;
        w_sweep_adv                        = 1'b0;
        w_sweep_start                      = 1'b0;
        unique case (r_state)
            IDLE: begin
                victim_way = hit ? hit_way : r_rr_ptr;
                if (pipe_req_valid) begin
                    if (flush_all_requested)
                        w_sweep_start = 1'b1;
                    else if (clflush_requested) begin
                        if (hit && victim_dirty) begin
                            set_new_l2_block_address           = 1'b1;
                            use_dirty_tag_for_l2_block_address = 1'b1;
                        end else begin
                            clear_selected_valid_bit = hit;
                            pipe_req_fulfilled       = 1'b1;
                        end
                    end else if (hit)
                        pipe_req_fulfilled = 1'b1;
                    else begin
                        set_new_l2_block_address           = 1'b1;
                        use_dirty_tag_for_l2_block_address = victim_valid && victim_dirty;
                    end
                end
            end
            WRITEBACK: begin
                l2_req_valid = 1'b1;
                l2_req_type  = STORE;
                flush_mode   = 1'b1;
                if (w_last_beat) begin
                    clear_selected_dirty_bit = 1'b1;
                    clear_selected_valid_bit = 1'b1;
                    set_new_l2_block_address = 1'b1;
                end
            end
            ALLOCATE: begin
                l2_req_valid = 1'b1;
                load_mode    = 1'b1;
                if (w_last_beat) begin
                    finish_new_line_install  = 1'b1;
                    clear_selected_dirty_bit = 1'b1;
                    w_rr_adv                 = 1'b1;
                end
            end
            FLUSH: begin
                l2_req_valid = 1'b1;
                l2_req_type  = STORE;
                flush_mode   = 1'b1;
                if (w_last_beat) begin
                    clear_selected_dirty_bit = 1'b1;
                    clear_selected_valid_bit = 1'b1;
                    pipe_req_fulfilled       = 1'b1;
                end
            end
            SWEEP_CHECK: begin
                sweep_mode = 1'b1;
                victim_way = r_sweep_way;
                if (victim_dirty) begin
                    set_new_l2_block_address           = 1'b1;
                    use_dirty_tag_for_l2_block_address = 1'b1;
                end else begin
                    clear_selected_valid_bit = 1'b1;
                    w_sweep_adv              = 1'b1;
                    pipe_req_fulfilled       = w_sweep_last;
                end
            end
            SWEEP_WB: begin
                sweep_mode   = 1'b1;
                victim_way   = r_sweep_way;
                l2_req_valid = 1'b1;
                l2_req_type  = STORE;
                flush_mode   = 1'b1;
                if (w_last_beat) begin
                    clear_selected_dirty_bit = 1'b1;
                    clear_selected_valid_bit = 1'b1;
                    w_sweep_adv              = 1'b1;
                    pipe_req_fulfilled       = w_sweep_last;
                end
            end
            default: begin
                pipe_req_fulfilled                 = 1'bx;
                l2_req_valid                       = 1'bx;
                l2_req_type                        = memory_operation_e'(1'bx);
                victim_way                         = 'x;
                sweep_mode                         = 1'bx;
                flush_mode                         = 1'bx;
                load_mode                          = 1'bx;
                set_new_l2_block_address           = 1'bx;
                use_dirty_tag_for_l2_block_address = 1'bx;
                clear_selected_dirty_bit           = 1'bx;
                clear_selected_valid_bit           = 1'bx;
                finish_new_line_install            = 1'bx;
            end
        endcase
    end

endmodule

// File: tb/tb_dcache_controller_nway.sv
// Directed bench for dcache_controller_nway (WAYS=2, WORDS_PER_LINE=4, SETS=4):
// an IDLE decode table plus hand sequences for misses, flushes, the full sweep and reset mid-transfer.
module tb_dcache_controller_nway;
    import xentry_pkg::*;

    localparam int WAYS = 2;
    localparam int WPL  = 4;
    localparam int SETS = 4;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              pipe_req_valid, clflush_requested, flush_all_requested, hit;
    logic [0:0]        hit_way;
    logic              victim_valid, vd_drv, victim_dirty, l2_req_fulfilled;
    logic              pipe_req_fulfilled, l2_req_valid;
    memory_operation_e l2_req_type;
    logic [0:0]        victim_way;
    logic [1:0]        beat;
    logic              sweep_mode;
    logic [1:0]        sweep_set;
    logic              flush_mode, load_mode, set_addr, use_dirty, clr_d, clr_v, fin, busy;
    logic              sweep_dirty_model = 1'b0;

    int checks = 0;
    int failures = 0;
    int n_fin, n_clrv, n_clrd, n_set, n_ful;

    // Datapath stand-in during the sweep: only (set 2, way 1) holds a dirty line.
    assign victim_dirty = sweep_dirty_model ? (sweep_mode && sweep_set == 2'd2 && victim_way == 1'b1) : vd_drv;

    always #5 clk = ~clk;

    dcache_controller_nway #(.WAYS(WAYS), .WORDS_PER_LINE(WPL), .SETS(SETS)) dut (
        .clk(clk), .reset_n(reset_n),
        .pipe_req_valid(pipe_req_valid), .clflush_requested(clflush_requested),
        .flush_all_requested(flush_all_requested), .hit(hit), .hit_way(hit_way),
        .victim_valid(victim_valid), .victim_dirty(victim_dirty),
        .l2_req_fulfilled(l2_req_fulfilled), .pipe_req_fulfilled(pipe_req_fulfilled),
        .l2_req_valid(l2_req_valid), .l2_req_type(l2_req_type), .victim_way(victim_way),
        .beat(beat), .sweep_mode(sweep_mode), .sweep_set(sweep_set),
        .flush_mode(flush_mode), .load_mode(load_mode),
        .set_new_l2_block_address(set_addr), .use_dirty_tag_for_l2_block_address(use_dirty),
        .clear_selected_dirty_bit(clr_d), .clear_selected_valid_bit(clr_v),
        .finish_new_line_install(fin), .busy(busy)
    );

    typedef struct {
        string nm;
        logic pv, cf, h, w, vv, vd;
        logic e_ful, e_vw, e_clrv, e_set, e_dirty;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic drive(input logic pv, input logic cf, input logic fa, input logic h,
                         input logic w, input logic vv, input logic vd);
        pipe_req_valid      = pv;
        clflush_requested   = cf;
        flush_all_requested = fa;
        hit                 = h;
        hit_way             = w;
        victim_valid        = vv;
        vd_drv              = vd;
        l2_req_fulfilled    = 1'b0;
    endtask

    // Runs one line transfer; L2 fulfils on every 'every'-th cycle. Strobes are tallied.
    task automatic run_beats(input logic exp_store, input int every, input logic exp_way);
        int b;
        int cyc;
        b = 0; cyc = 0;
        n_fin = 0; n_clrv = 0; n_clrd = 0; n_set = 0; n_ful = 0;
        while (b < WPL && cyc < 64) begin
            next_cycle();
            l2_req_fulfilled = ((cyc % every) == (every - 1));
            sample();
            chk("xfer_l2_valid", l2_req_valid, 1);
            chk("xfer_type", l2_req_type, exp_store);
            chk("xfer_load_mode", load_mode, !exp_store);
            chk("xfer_flush_mode", flush_mode, exp_store);
            chk("xfer_way", victim_way, exp_way);
            chk("xfer_busy", busy, 1);
            if (l2_req_fulfilled) begin
                chk("xfer_beat", beat, b);
                b++;
            end
            if (!(l2_req_fulfilled && b == WPL))
                chk("xfer_no_early_strobe", {fin, clr_v, clr_d, set_addr, pipe_req_fulfilled}, 0);
            n_fin  += int'(fin);
            n_clrv += int'(clr_v);
            n_clrd += int'(clr_d);
            n_set  += int'(set_addr);
            n_ful  += int'(pipe_req_fulfilled);
            cyc++;
        end
        if (b < WPL) chk("xfer_timeout", b, WPL);
    endtask

    task automatic seq_sweep();
        int cyc, ck_clr, wb_beats, wb_clr, dset;
        logic done;
        cyc = 0; ck_clr = 0; wb_beats = 0; wb_clr = 0; dset = 0; done = 1'b0;
        sweep_dirty_model = 1'b1;
        next_cycle();
        drive(1, 0, 1, 0, 0, 0, 0);
        sample();
        chk("sweep_start_busy", busy, 0);
        chk("sweep_start_ful", pipe_req_fulfilled, 0);
        while (!done && cyc < 60) begin
            next_cycle();
            drive(0, 0, 0, 0, 0, 0, 0);
            l2_req_fulfilled = 1'b1;
            sample();
            chk("sweep_mode", sweep_mode, 1);
            if (!l2_req_valid && clr_v) ck_clr++;
            if (l2_req_valid && l2_req_fulfilled) wb_beats++;
            if (l2_req_valid && clr_v) wb_clr++;
            if (set_addr && use_dirty) begin
                dset++;
                chk("sweep_dirty_set", sweep_set, 2);
                chk("sweep_dirty_way", victim_way, 1);
            end
            if (pipe_req_fulfilled) begin
                done = 1'b1;
                chk("sweep_end_set", sweep_set, 3);
                chk("sweep_end_way", victim_way, 1);
            end
            cyc++;
        end
        chk("sweep_done", done, 1);
        chk("sweep_cycles", cyc, 12);
        chk("sweep_clean_clears", ck_clr, 7);
        chk("sweep_wb_beats", wb_beats, 4);
        chk("sweep_wb_clears", wb_clr, 1);
        chk("sweep_dirty_entries", dset, 1);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0);
        sample();
        chk("sweep_after_busy", busy, 0);
        chk("sweep_after_mode", sweep_mode, 0);
        sweep_dirty_model = 1'b0;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        //                nm               pv cf h  w  vv vd  ful vw clrv set dty
        vecs[0] = '{"idle",            0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0};
        vecs[1] = '{"hit_w1",          1, 0, 1, 1, 1, 0,  1, 1, 0, 0, 0};
        vecs[2] = '{"hit_w0_dirty",    1, 0, 1, 0, 1, 1,  1, 0, 0, 0, 0};
        vecs[3] = '{"hit_no_valid",    0, 0, 1, 1, 1, 0,  0, 1, 0, 0, 0};
        vecs[4] = '{"clf_miss",        1, 1, 0, 1, 1, 1,  1, 0, 0, 0, 0};
        vecs[5] = '{"clf_clean_hit",   1, 1, 1, 1, 1, 0,  1, 1, 1, 0, 0};
        vecs[6] = '{"miss_no_valid",   0, 0, 0, 0, 1, 1,  0, 0, 0, 0, 0};

        drive(0, 0, 0, 0, 0, 0, 0);
        sample();
        chk("rst_busy", busy, 0);
        chk("rst_l2_valid", l2_req_valid, 0);
        chk("rst_l2_type", l2_req_type, LOAD);
        chk("rst_way", victim_way, 0);
        chk("rst_beat", beat, 0);
        chk("rst_sweep_mode", sweep_mode, 0);
        chk("rst_ful", pipe_req_fulfilled, 0);
        @(posedge clk);
        #1 reset_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            next_cycle();
            drive(vecs[i].pv, vecs[i].cf, 0, vecs[i].h, vecs[i].w, vecs[i].vv, vecs[i].vd);
            sample();
            chk({vecs[i].nm, "_ful"},   pipe_req_fulfilled, vecs[i].e_ful);
            chk({vecs[i].nm, "_way"},   victim_way, vecs[i].e_vw);
            chk({vecs[i].nm, "_clrv"},  clr_v, vecs[i].e_clrv);
            chk({vecs[i].nm, "_set"},   set_addr, vecs[i].e_set);
            chk({vecs[i].nm, "_dirty"}, use_dirty, vecs[i].e_dirty);
            chk({vecs[i].nm, "_busy"},  busy, 0);
            chk({vecs[i].nm, "_l2v"},   l2_req_valid, 0);
        end

        // Clean miss into way 0, L2 answering every other cycle.
        next_cycle();
        drive(1, 0, 0, 0, 0, 0, 0);
        sample();
        chk("cmiss_set", set_addr, 1);
        chk("cmiss_dirty", use_dirty, 0);
        chk("cmiss_way", victim_way, 0);
        run_beats(0, 2, 0);
        chk("cmiss_fin", n_fin, 1);
        chk("cmiss_clrd", n_clrd, 1);
        chk("cmiss_clrv", n_clrv, 0);
        next_cycle();
        drive(1, 0, 0, 1, 0, 1, 0);
        sample();
        chk("cmiss_rehit_ful", pipe_req_fulfilled, 1);
        chk("cmiss_rehit_busy", busy, 0);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0);
        sample();
        chk("cmiss_rr_ptr", victim_way, 1);

        // Dirty miss into way 1: write-back then allocate with no gap.
        next_cycle();
        drive(1, 0, 0, 0, 0, 1, 1);
        sample();
        chk("dmiss_set", set_addr, 1);
        chk("dmiss_dirty", use_dirty, 1);
        chk("dmiss_way", victim_way, 1);
        run_beats(1, 1, 1);
        chk("dmiss_wb_clrv", n_clrv, 1);
        chk("dmiss_wb_clrd", n_clrd, 1);
        chk("dmiss_wb_set", n_set, 1);
        chk("dmiss_wb_fin", n_fin, 0);
        run_beats(0, 1, 1);
        chk("dmiss_al_fin", n_fin, 1);
        chk("dmiss_al_clrv", n_clrv, 0);
        next_cycle();
        drive(1, 0, 0, 1, 1, 1, 0);
        sample();
        chk("dmiss_rehit_ful", pipe_req_fulfilled, 1);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0);
        sample();
        chk("dmiss_rr_ptr", victim_way, 0);

        // clflush of a dirty line in way 1.
        next_cycle();
        drive(1, 1, 0, 1, 1, 1, 1);
        sample();
        chk("clf_set", set_addr, 1);
        chk("clf_dirty", use_dirty, 1);
        chk("clf_ful0", pipe_req_fulfilled, 0);
        run_beats(1, 1, 1);
        chk("clf_clrv", n_clrv, 1);
        chk("clf_clrd", n_clrd, 1);
        chk("clf_ful", n_ful, 1);
        chk("clf_set_end", n_set, 0);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0);
        sample();
        chk("clf_after_busy", busy, 0);

        seq_sweep();

        // Reset during beat 2 of an allocate, then a fresh miss restarts at beat 0.
        next_cycle();
        drive(1, 0, 0, 0, 0, 0, 0);
        sample();
        chk("rmid_set", set_addr, 1);
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            l2_req_fulfilled = 1'b1;
            sample();
        end
        chk("rmid_beat2", beat, 2);
        #1;
        reset_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("rmid_busy", busy, 0);
        chk("rmid_l2v", l2_req_valid, 0);
        chk("rmid_beat", beat, 0);
        chk("rmid_load_mode", load_mode, 0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        drive(1, 0, 0, 0, 0, 0, 0);
        sample();
        chk("rmid_remiss_set", set_addr, 1);
        chk("rmid_remiss_way", victim_way, 0);
        run_beats(0, 1, 0);
        chk("rmid_fin", n_fin, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dcache_controller_nway.md
# dcache_controller_nway

Parametrised successor to the direct-mapped data-cache controller FSM. It handles WAYS-way set-associative lines with a configurable number of words per line, and owns its own beat counter and round-robin victim pointer. It adds a whole-cache flush sweep alongside single-line clflush. The block sits between the pipeline request port, the tag/data datapath and the L2 request port, and produces only control strobes; the datapath owns all arrays.

## Interface
- WAYS, default 2: associativity, ≥1.
- WORDS_PER_LINE, default 4: L2 beats per line, power of 2, ≥2.
- SETS, default 64: sets per way, power of 2.
- Derived: WAY_W = max(1,$clog2(WAYS)), BEAT_W = $clog2(WORDS_PER_LINE), SET_W = $clog2(SETS).
- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- pipe_req_valid  in  1  pipeline request present (load/store/clflush).
- clflush_requested  in  1  current request is a single-line flush.
- flush_all_requested  in  1  whole-cache write-back-and-invalidate request.
- hit  in  1  tag match in some way, valid only with pipe_req_valid.
- hit_way  in  WAY_W  way that matched.
- victim_valid  in  1  valid bit of (set, victim_way), combinational from datapath.
- victim_dirty  in  1  dirty bit of (set, victim_way).
- l2_req_fulfilled  in  1  L2 accepted/returned one beat this cycle.
- pipe_req_fulfilled  out  1  one-cycle completion pulse to pipeline.
- l2_req_valid  out  1  beat request to L2.
- l2_req_type  out  memory_operation_e  LOAD or STORE (xentry_pkg).
- victim_way  out  WAY_W  way the datapath must index.
- beat  out  BEAT_W  word index of current L2 beat.
- sweep_mode  out  1  datapath indexes by sweep_set instead of the pipe address.
- sweep_set  out  SET_W  set under sweep.
- flush_mode, load_mode  out  1 each  datapath read-for-L2 / write-from-L2 select.
- set_new_l2_block_address, use_dirty_tag_for_l2_block_address  out  1 each  latch L2 block address, from victim tag or from request tag.
- clear_selected_dirty_bit, clear_selected_valid_bit, finish_new_line_install  out  1 each  single-cycle strobes on (set, victim_way).
- busy  out  1  state ≠ IDLE.

## Operation
- States: IDLE, WRITEBACK, ALLOCATE, FLUSH, SWEEP_CHECK, SWEEP_WB.
- IDLE priority: flush_all_requested > clflush_requested > normal access; nothing happens without pipe_req_valid.
- victim_way in IDLE: hit_way if hit, else rr_ptr. Latched into target_way on leaving IDLE and driven from target_way afterwards. In sweep states it is driven by sweep_way.
- Normal hit: pipe_req_fulfilled=1, stay IDLE.
- Clean miss (victim invalid or clean): set_new_l2_block_address, go to ALLOCATE.
- Dirty miss: set_new_l2_block_address and use_dirty_tag_for_l2_block_address, go to WRITEBACK.
- clflush miss: fulfilled, stay IDLE.
- clflush hit, clean: clear_selected_valid_bit and fulfilled.
- clflush hit, dirty: dirty tag, go to FLUSH.
- WRITEBACK: STORE beats. On the last beat: clear dirty+valid, set_new_l2_block_address, go to ALLOCATE.
- ALLOCATE: LOAD beats. On the last beat: finish_new_line_install, clear_selected_dirty_bit, rr_ptr += 1 mod WAYS, go to IDLE. The request is re-presented and then hits.
- FLUSH: STORE beats. On the last beat: clear dirty+valid, fulfilled, go to IDLE.
- flush_all: sweep_set=0, sweep_way=0, go to SWEEP_CHECK.
- SWEEP_CHECK: if victim_dirty, set address with dirty tag and go to SWEEP_WB. Otherwise clear_selected_valid_bit and advance.
- SWEEP_WB: STORE beats. On the last beat: clear dirty+valid, advance, return to SWEEP_CHECK.
- Advance order: way inner, set outer. After (SETS-1, WAYS-1): fulfilled, go to IDLE.
- Beat counter: reset to 0 on every state entry and increments on l2_req_fulfilled. Last beat is l2_req_fulfilled && beat==WORDS_PER_LINE-1, and the counter wraps to 0 there.
- l2_req_valid=1 continuously in WRITEBACK/ALLOCATE/FLUSH/SWEEP_WB.
- load_mode=1 only in ALLOCATE. flush_mode=1 in the STORE states.
- Unreachable state: outputs X, next state X, for simulation detection.

## Timing
- Reset values: state IDLE, rr_ptr/target_way/sweep counters/beat 0. All outputs 0 except l2_req_type=LOAD and victim_way=hit_way/rr_ptr combinational.
- Hit latency: 0 cycles (pipe_req_fulfilled combinational in the same cycle).
- Clean-miss latency: 1 + WORDS_PER_LINE beats + 1 re-evaluation cycle, excluding L2 stall cycles.
- Dirty miss: 2·WORDS_PER_LINE beats plus the same overhead.
- All Mealy strobes and state changes take effect in the cycle of the last l2_req_fulfilled. No idle bubble between WRITEBACK and ALLOCATE.
- Clean sweep entry: 1 cycle each. Minimum full sweep of an all-clean cache: SETS·WAYS + 1 cycles.
- Request inputs are ignored while busy=1; the pipeline holds its request until fulfilled.
- Asynchronous reset mid-transfer: immediate return to IDLE and outputs to reset values; the in-flight L2 beat is abandoned.

## Test plan
- WAYS=2, WORDS_PER_LINE=4, SETS=4, hit in way 1 → pipe_req_fulfilled=1 the same cycle, victim_way=1, busy stays 0.
- Clean miss, rr_ptr=0, L2 fulfilling every other cycle → 4 LOAD beats with beat 0..3, finish_new_line_install exactly once, rr_ptr=1 afterwards.
- Dirty miss → 4 STORE beats with use_dirty_tag asserted on entry, then clear dirty+valid and 4 LOAD beats immediately following, no gap cycle.
- clflush of a dirty hit way 1 → FLUSH with 4 STORE beats, then clear valid+dirty on way 1 and fulfilled. clflush miss → fulfilled same cycle.
- flush_all with only (set 2, way 1) dirty → 7 single-cycle clears, 1 write-back of 4 beats, fulfilled after the (3,1) entry.
- reset_n low during beat 2 of ALLOCATE → busy=0 and l2_req_valid=0 immediately. After release, a miss restarts at beat 0.
